// File: rtl/signed_divider_seq_if.sv
// signed_divider_seq_if: handshake, operand/result and comparator-loop
// signals of the sequential 4-bit signed divider.
//   start/dividend/divisor : request and operands (driven by the requester)
//   busy/done              : status; done is a one-cycle pulse
//   quotient/remainder     : signed results, held until the next accepted start
//   dz/ovf/cmp_err         : divide-by-zero, -8/-1 overflow, comparator fault
//   cmp_a/cmp_b/hel        : operands to, and one-hot result from, the
//                            external 4-bit magnitude comparator
// slave  = divider side, master = requester/comparator side.
interface signed_divider_seq_if;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       dz;
    logic       ovf;
    logic [3:0] cmp_a;
    logic [3:0] cmp_b;
    logic [2:0] hel;
    logic       cmp_err;

    modport slave (
        input  start, dividend, divisor, hel,
        output busy, done, quotient, remainder, dz, ovf, cmp_a, cmp_b, cmp_err
    );

    modport master (
        output start, dividend, divisor, hel,
        input  busy, done, quotient, remainder, dz, ovf, cmp_a, cmp_b, cmp_err
    );
endinterface

// File: rtl/signed_divider_seq.sv
// signed_divider_seq: sequential 4-bit signed restoring divider.
// Works on magnitudes, one quotient bit per cycle, using an external
// combinational magnitude comparator (cmp_a/cmp_b out, hel back in the same
// cycle) to decide each bit; signs are applied in a final FIX cycle.
// Truncating division: remainder carries the dividend's sign.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : signed_divider_seq_if.slave (start/operands, busy/done, results,
//          dz/ovf/cmp_err flags, comparator operands and hel result)
// Optional feature macro: DIV_HEL_CHECK_EN -- when defined, a hel value that
// is not exactly one-hot during ITER aborts the operation and sets cmp_err;
// when undefined cmp_err stays 0 and hel is trusted.
module signed_divider_seq (
    input  logic                 clk,
    input  logic                 rst,
    signed_divider_seq_if.slave  bus
);

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    an_q;
    logic [W-1:0]    ad_q;
    logic            sn_q;
    logic            sq_q;
    logic [W-1:0]    pr_q;
    logic [W-1:0]    q_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;
    logic [W-1:0]    quot_q;
    logic [W-1:0]    rem_q;
    logic            dz_q;
    logic            ovf_q;
    logic            cmp_err_q;
    logic [W-1:0]    cmp_a_q;
    logic [W-1:0]    cmp_b_q;

    logic [W-1:0]    an_in_c;
    logic [W-1:0]    ad_in_c;
    logic            take_c;
    logic            abort_c;
    logic [CW-1:0]   bit_idx_c;
    logic [CW-1:0]   nxt_idx_c;
    logic [W-1:0]    pr_step_d;
    logic [W-1:0]    q_step_d;
    logic [W-1:0]    cmp_a_nxt_d;
    logic [W-1:0]    quot_fix_d;
    logic [W-1:0]    rem_fix_d;
    logic            ovf_fix_d;
    logic            unused_hel0;

    // Two's complement magnitude; -8 maps to 4'b1000 as an unsigned value.
    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? W'(-x) : x;
    endfunction

    // Operand magnitudes taken at start.
    always_comb begin
        an_in_c = mag(bus.dividend);
        ad_in_c = mag(bus.divisor);
    end

    // One restoring step: cmp_a_q already holds {PR[2:0], |N|[3-cnt]}.
    always_comb begin
        take_c      = bus.hel[2] | bus.hel[1];
        bit_idx_c   = CW'(CW'(W - 1) - cnt_q);
        nxt_idx_c   = CW'(bit_idx_c - CW'(1));
        pr_step_d   = take_c ? W'(cmp_a_q - ad_q) : cmp_a_q;
        q_step_d    = q_q;
        q_step_d[bit_idx_c] = take_c;
        cmp_a_nxt_d = {pr_step_d[W-2:0], an_q[nxt_idx_c]};
`ifdef DIV_HEL_CHECK_EN
        abort_c     = !((bus.hel == 3'b100) || (bus.hel == 3'b010) || (bus.hel == 3'b001));
`else
        abort_c     = 1'b0;
`endif
    end

    assign unused_hel0 = bus.hel[0];

    // Sign fix-up of the magnitude results.
    always_comb begin
        ovf_fix_d = 1'b0;
        if (dz_q) begin
            quot_fix_d = '0;
            rem_fix_d  = sn_q ? W'(-an_q) : an_q;
        end else begin
            quot_fix_d = sq_q ? W'(-q_q) : q_q;
            rem_fix_d  = sn_q ? W'(-pr_q) : pr_q;
            ovf_fix_d  = !sq_q && (q_q == 4'b1000);
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            an_q      <= '0;
            ad_q      <= '0;
            sn_q      <= 1'b0;
            sq_q      <= 1'b0;
            pr_q      <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            cmp_err_q <= 1'b0;
            cmp_a_q   <= '0;
            cmp_b_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        an_q      <= an_in_c;
                        ad_q      <= ad_in_c;
                        sn_q      <= bus.dividend[W-1];
                        sq_q      <= bus.dividend[W-1] ^ bus.divisor[W-1];
                        pr_q      <= '0;
                        q_q       <= '0;
                        cnt_q     <= '0;
                        ovf_q     <= 1'b0;
                        cmp_err_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (bus.divisor == '0) begin
                            dz_q    <= 1'b1;
                            state_q <= S_FIX;
                        end else begin
                            dz_q    <= 1'b0;
                            // First step compares {000, |N|[3]} against |D|.
                            cmp_a_q <= {(W-1)'(0), an_in_c[W-1]};
                            cmp_b_q <= ad_in_c;
                            state_q <= S_ITER;
                        end
                    end
                end

                S_ITER: begin
                    if (abort_c) begin
                        cmp_err_q <= 1'b1;
                        quot_q    <= '0;
                        rem_q     <= '0;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        cmp_a_q   <= '0;
                        cmp_b_q   <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        pr_q  <= pr_step_d;
                        q_q   <= q_step_d;
                        cnt_q <= CW'(cnt_q + CW'(1));
                        if (cnt_q == CW'(W - 1)) begin
                            cmp_a_q <= '0;
                            cmp_b_q <= '0;
                            state_q <= S_FIX;
                        end else begin
                            cmp_a_q <= cmp_a_nxt_d;
                        end
                    end
                end

                S_FIX: begin
                    // Divide-by-zero spends one extra FIX cycle so done
                    // lands two edges after the accepting edge.
                    if (dz_q && (cnt_q == '0)) begin
                        cnt_q <= CW'(1);
                    end else begin
                        quot_q  <= quot_fix_d;
                        rem_q   <= rem_fix_d;
                        ovf_q   <= ovf_fix_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.dz        = dz_q;
    assign bus.ovf       = ovf_q;
    assign bus.cmp_err   = cmp_err_q;
    assign bus.cmp_a     = cmp_a_q;
    assign bus.cmp_b     = cmp_b_q;

endmodule

// File: tb/tb_signed_divider_seq.sv
// Testbench for signed_divider_seq: models the external comparator,
// runs a directed vector table, hand-written corner sequences and random
// operands checked against an integer-arithmetic reference.
module tb_signed_divider_seq;

    logic clk;
    logic rst;
    logic hel_force;
    int   checks;
    int   errors;

    signed_divider_seq_if dif ();

    signed_divider_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational magnitude comparator in front of the divider.
    always_comb begin
        if (hel_force)                 dif.hel = 3'b000;
        else if (dif.cmp_a > dif.cmp_b) dif.hel = 3'b100;
        else if (dif.cmp_a == dif.cmp_b) dif.hel = 3'b010;
        else                           dif.hel = 3'b001;
    end

    typedef struct {
        logic [3:0] n;
        logic [3:0] d;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        logic       ov;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Truncating signed division from plain integer arithmetic.
    function automatic void ref_div(input logic [3:0] n, input logic [3:0] d,
                                    output logic [3:0] q, output logic [3:0] r,
                                    output logic dzv, output logic ov);
        int ni;
        int di;
        ni  = $signed(n);
        di  = $signed(d);
        dzv = 1'b0;
        ov  = 1'b0;
        if (di == 0) begin
            dzv = 1'b1;
            q   = 4'd0;
            r   = n;
        end else if (ni == -8 && di == -1) begin
            ov = 1'b1;
            q  = 4'b1000;
            r  = 4'd0;
        end else begin
            q = 4'(ni / di);
            r = 4'(ni % di);
        end
    endfunction

    // Issue one operation; returns done latency, cmp_a per ITER cycle, busy behaviour.
    task automatic do_op(input logic [3:0] n, input logic [3:0] d, input bit poke,
                         output int lat, output logic [15:0] seq, output bit busy_ok);
        lat     = 0;
        seq     = '0;
        busy_ok = 1'b1;
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = n;
        dif.divisor  = d;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        if (!dif.busy) busy_ok = 1'b0;
        seq[3:0] = dif.cmp_a;
        for (int i = 1; i <= 20; i++) begin
            if (poke && i == 2) begin
                @(negedge clk);
                dif.start    = 1'b1;
                dif.dividend = ~n;
                dif.divisor  = 4'd1;
            end
            @(posedge clk);
            #1;
            dif.start = 1'b0;
            if (dif.done) begin
                lat = i;
                if (dif.busy) busy_ok = 1'b0;
                break;
            end
            if (!dif.busy) busy_ok = 1'b0;
            if (i < 4) seq[4*i +: 4] = dif.cmp_a;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [3:0] n, input logic [3:0] d,
                                 input bit poke, input logic [3:0] eq, input logic [3:0] er,
                                 input logic edz, input logic eov);
        int          lat;
        logic [15:0] seq;
        bit          busy_ok;
        do_op(n, d, poke, lat, seq, busy_ok);
        chk({tag, " latency"}, 32'(lat), edz ? 32'd2 : 32'd5);
        chk({tag, " busy"}, 32'(busy_ok), 32'd1);
        chk({tag, " quotient"}, 32'(dif.quotient), 32'(eq));
        chk({tag, " remainder"}, 32'(dif.remainder), 32'(er));
        chk({tag, " dz"}, 32'(dif.dz), 32'(edz));
        chk({tag, " ovf"}, 32'(dif.ovf), 32'(eov));
        chk({tag, " cmp_err"}, 32'(dif.cmp_err), 32'd0);
    endtask

    initial begin
        vec_t        vecs [6];
        int          lat;
        logic [15:0] seq;
        bit          busy_ok;
        bit          done_seen;
        logic [3:0]  rn, rd, rq, rr;
        logic        rdz, rov;

        checks       = 0;
        errors       = 0;
        hel_force    = 1'b0;
        rst          = 1'b0;
        dif.start    = 1'b0;
        dif.dividend = 4'd0;
        dif.divisor  = 4'd0;

        vecs[0] = '{n: 4'd7,    d: 4'd2,    q: 4'b0011, r: 4'b0001, dz: 1'b0, ov: 1'b0};
        vecs[1] = '{n: 4'b1001, d: 4'd2,    q: 4'b1101, r: 4'b1111, dz: 1'b0, ov: 1'b0};
        vecs[2] = '{n: 4'b1000, d: 4'd3,    q: 4'b1110, r: 4'b1110, dz: 1'b0, ov: 1'b0};
        vecs[3] = '{n: 4'b1000, d: 4'b1111, q: 4'b1000, r: 4'b0000, dz: 1'b0, ov: 1'b1};
        vecs[4] = '{n: 4'd5,    d: 4'd0,    q: 4'b0000, r: 4'b0101, dz: 1'b1, ov: 1'b0};
        vecs[5] = '{n: 4'b0110, d: 4'b1101, q: 4'b1110, r: 4'b0000, dz: 1'b0, ov: 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs",
            32'({dif.busy, dif.done, dif.quotient, dif.remainder, dif.dz, dif.ovf,
                 dif.cmp_err, dif.cmp_a, dif.cmp_b}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // cmp_a walk for 7/2: 0,1,3,3 with cmp_b = |D|.
        do_op(4'd7, 4'd2, 1'b0, lat, seq, busy_ok);
        chk("7/2 cmp_a sequence", 32'(seq), 32'h3310);
        chk("7/2 latency", 32'(lat), 32'd5);
        chk("7/2 quotient", 32'(dif.quotient), 32'd3);

        // Directed table; each start lands in the previous done cycle.
        for (int i = 0; i < 6; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].n, vecs[i].d, 1'b0,
                          vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov);
        end

        // cmp_b carries |D| during ITER, including |-8| = 8.
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 4'd7;
        dif.divisor  = 4'b1000;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        chk("cmp_b |-8|", 32'(dif.cmp_b), 32'd8);
        repeat (6) @(posedge clk);
        #1;
        chk("idle cmp operands", 32'({dif.cmp_a, dif.cmp_b}), 32'd0);
        chk("7/-8 quotient", 32'(dif.quotient), 32'd0);
        chk("7/-8 remainder", 32'(dif.remainder), 32'd7);

        // start pulsed while busy must be ignored.
        run_and_check("poke busy", 4'b1011, 4'd3, 1'b1, 4'b1111, 4'b1110, 1'b0, 1'b0);

        // Reset during the second ITER cycle aborts without done.
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 4'd7;
        dif.divisor  = 4'd2;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid-ITER reset outputs",
            32'({dif.busy, dif.done, dif.quotient, dif.remainder, dif.dz, dif.ovf,
                 dif.cmp_err, dif.cmp_a, dif.cmp_b}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (dif.done || dif.busy) done_seen = 1'b1;
        end
        chk("no done after abort", 32'(done_seen), 32'd0);
        run_and_check("after reset 6/-3", 4'b0110, 4'b1101, 1'b0, 4'b1110, 4'b0000, 1'b0, 1'b0);

`ifdef DIV_HEL_CHECK_EN
        // Non-one-hot hel in the first ITER cycle.
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 4'd7;
        dif.divisor  = 4'd2;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        hel_force = 1'b1;
        @(posedge clk);
        #1;
        hel_force = 1'b0;
        chk("hel fault done", 32'(dif.done), 32'd1);
        chk("hel fault cmp_err", 32'(dif.cmp_err), 32'd1);
        chk("hel fault results", 32'({dif.quotient, dif.remainder}), 32'd0);
        @(posedge clk);
        #1;
        chk("hel fault cmp_err held", 32'(dif.cmp_err), 32'd1);
        run_and_check("after hel fault", 4'd7, 4'd2, 1'b0, 4'b0011, 4'b0001, 1'b0, 1'b0);
`endif

        // Random operands against the reference model.
        for (int i = 0; i < 60; i++) begin
            rn = 4'($urandom_range(0, 15));
            rd = 4'($urandom_range(0, 15));
            ref_div(rn, rd, rq, rr, rdz, rov);
            run_and_check($sformatf("rand%0d %0h/%0h", i, rn, rd), rn, rd,
                          bit'($urandom_range(0, 3) == 0), rq, rr, rdz, rov);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/signed_divider_seq.md
# signed_divider_seq

Sequential 4-bit signed restoring divider for the signed calculator datapath.
- Sits directly downstream of the 4-bit magnitude comparator: it drives the comparator's operands (`cmp_a`, `cmp_b`) and consumes its one-hot `hel` result each iteration.
- From that result it decides quotient bits, and produces signed quotient/remainder with a start/busy/done handshake.
- Subtraction of the divisor from the partial remainder is done internally.

## Interface
Parameters: none (width fixed at 4 bits).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `dividend`  in  4  two's complement N; sampled with `start`.
- `divisor`  in  4  two's complement D; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse; results valid from this cycle.
- `quotient`  out  4  signed Q, held until the next accepted start.
- `remainder`  out  4  signed R, held until the next accepted start.
- `dz`  out  1  divide-by-zero flag, held with results.
- `ovf`  out  1  overflow flag (-8 / -1), held with results.
- `cmp_a`  out  4  comparator operand A; shifted partial remainder.
- `cmp_b`  out  4  comparator operand B; |D|.
- `hel`  in  3  comparator result, same cycle: [2] A>B, [1] A==B, [0] A<B.
- `cmp_err`  out  1  comparator result fault (see Configuration).

## Operation
- States: IDLE, ITER, FIX.
- **IDLE, `start`=1:**
  - Latch |N| and |D| as 4-bit unsigned values; -8 gives magnitude 4'b1000.
  - Latch sN = N[3] and sQ = N[3]^D[3].
  - Clear PR, `dz`, `ovf`, `cmp_err`; set cnt=0.
  - If D==0: set `dz` and go to FIX. Otherwise go to ITER.
- **ITER, step cnt = 0..3:**
  - `cmp_a` = {PR[2:0], |N|[3-cnt]}; `cmp_b` = |D|.
  - If `hel`[2] or `hel`[1]: PR <= `cmp_a` - |D| and q[3-cnt] <= 1. Otherwise PR <= `cmp_a` and q[3-cnt] <= 0.
  - After cnt=3, go to FIX. PR stays below |D| ≤ 8, so `cmp_a` ≤ 15 and never exceeds 4 bits.
- **FIX:**
  - `quotient` = sQ ? -q : q, 4-bit wrap.
  - `remainder` = sN ? -PR : PR; truncating division, remainder takes the dividend's sign.
  - `ovf` = 1 when sQ=0 and q=4'b1000; `quotient` = 4'b1000 in that case.
  - `dz` case: `quotient` = 0, `remainder` = `dividend`.
  - Pulse `done`, return to IDLE.
- Outside ITER: `cmp_a` = `cmp_b` = 0.
- `start` while busy: ignored.
- `start` in the `done` cycle: accepted, because the state is already IDLE.

## Timing
- Accepted start at edge k:
  - ITER occupies cycles k..k+3; edges k+1..k+4 perform the four steps.
  - FIX occupies cycle k+4.
  - `done`=1 and new results appear after edge k+5.
- `dz` path: `done` after edge k+2.
- `hel` is used combinationally in the same cycle `cmp_a`/`cmp_b` are driven; the comparator has no register.
- Reset (`rst`=0, any time, including mid-ITER):
  - State IDLE.
  - `busy`, `done`, `quotient`, `remainder`, `dz`, `ovf`, `cmp_err` = 0; `cmp_a`, `cmp_b` = 0.
  - No `done` is issued for an aborted operation.

## Configuration
- `DIV_HEL_CHECK_EN` defined:
  - In ITER, `hel` that is not exactly one-hot sets `cmp_err`=1.
  - The operation aborts: `quotient` = `remainder` = 0, `done` pulses on the next edge, state returns to IDLE.
  - `cmp_err` holds until the next accepted start.
- `DIV_HEL_CHECK_EN` undefined:
  - `cmp_err` is tied 0.
  - Decision is `hel`[2] | `hel`[1] with no checking.

## Test plan
- N=7, D=2, start at edge k -> `cmp_a` sequence 0,1,3,3 across the four ITER cycles; `done` after edge k+5; `quotient`=0011, `remainder`=0001, `dz`=`ovf`=0.
- N=-7 (1001), D=2 -> `quotient`=1101 (-3), `remainder`=1111 (-1); N=-8, D=3 -> `quotient`=1110, `remainder`=1110.
- N=-8, D=-1 -> `ovf`=1, `quotient`=1000, `remainder`=0000.
- N=5, D=0 -> `dz`=1, `quotient`=0000, `remainder`=0101, `done` after edge k+2.
- `rst` low during the second ITER cycle -> all outputs 0, no `done`; then N=6, D=-3 -> `quotient`=1110, `remainder`=0000. Also: `start` pulsed while busy is ignored, and `start` in the `done` cycle is accepted.
- With `DIV_HEL_CHECK_EN`: force `hel`=000 in the first ITER cycle -> `cmp_err`=1, `done` next cycle, `quotient`=`remainder`=0.
